r2sdf_stage_ctrl: RTL and testbench
===================================

// Module: r2sdf_stage_ctrl
// PURPOSE
//  Sequencer for one radix-2 single-path-delay FFT stage. Drives the 2-bit
//  butterfly state code, the HALF-deep delay-line shift enable, the twiddle
//  ROM address and the output valid/last flags.
//  One frame = HALF WAITING beats, then HALF FIRST beats (input-paced),
//  then HALF SECOND beats (self-paced drain, input held off).
//  One instance per stage; stages are cascaded via out_valid -> in_valid.
// PARAMETERS
//  HALF       16  delay-line depth = N/2; power of two, >= 2
//  CW          4  counter width, = log2(HALF)
//  TW_AW       4  twiddle ROM address width
//  TW_STRIDE   1  twiddle step per SECOND beat (2^k for stage k of a 32-pt FFT)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      upstream sample present this cycle
//  in_ready   out  1      stage accepts a sample (beat = in_valid & in_ready)
//  state      out  2      butterfly code: 00 IDLE, 01 FIRST, 10 SECOND, 11 WAITING
//  sr_en      out  1      delay line shifts this cycle
//  tw_addr    out  TW_AW  twiddle ROM address, valid in SECOND
//  out_valid  out  1      butterfly output valid this cycle
//  out_last   out  1      last output beat of the frame
//  busy       out  1      phase != IDLE
//  err        out  1      sticky protocol error (STALL_ERR_EN builds only)
// BEHAVIOUR
//  - Registers: phase[1:0] (codes as state), cnt[CW-1:0]. Async reset:
//    phase=IDLE, cnt=0, err=0. All outputs are combinational from phase,
//    cnt and in_valid; zero-cycle latency to the combinational butterfly.
//  - in_ready = (phase != SECOND).
//  - IDLE: state = in_valid ? WAITING : IDLE. On a beat: cnt<=1, phase<=WAITING.
//    This gives back-to-back frames with no dead cycle.
//  - WAITING: state = WAITING. On a beat: cnt++; when cnt==HALF-1: cnt<=0,
//    phase<=FIRST.
//  - FIRST: state = FIRST. On a beat: cnt++; when cnt==HALF-1: cnt<=0,
//    phase<=SECOND.
//  - SECOND: state = SECOND every cycle; in_valid is ignored. cnt++ each cycle;
//    when cnt==HALF-1: cnt<=0, phase<=IDLE.
//  - Input gaps in WAITING/FIRST: no beat, cnt and phase hold, sr_en=0,
//    out_valid=0. The butterfly state stays at the phase code.
//  - sr_en = (in_valid & phase!=SECOND) | (phase==SECOND).
//  - out_valid = (phase==FIRST & in_valid) | (phase==SECOND).
//  - out_last = (phase==SECOND & cnt==HALF-1).
//  - tw_addr = (cnt*TW_STRIDE) mod 2^TW_AW in SECOND, else 0. FIRST outputs
//    are unmultiplied sums.
//  - HALF==2: each phase lasts two beats.
//  - A frame cannot be aborted except by rst_n. Reset mid-frame returns to
//    IDLE on the next edge; delay-line contents are don't-care. The first
//    frame after release starts clean.
// CONFIGURATION
//  FFT_CTRL_STALL_ERR_EN defined:
//    err is set, and held until rst_n, when in_valid=0 in WAITING with cnt!=0
//    or in FIRST; i.e. the stage requires gap-free input once a frame starts.
//    Sequencing is otherwise unchanged.
//  FFT_CTRL_STALL_ERR_EN undefined:
//    err is tied 0 and gaps are legal stalls.
// TESTING (HALF=16, TW_STRIDE=1)
//  - Reset: rst_n=0 with in_valid=1 -> state=00, in_ready=1, out_valid=0,
//    err=0, busy=0.
//  - One frame, 32 continuous beats: state=11 x16, 01 x16, 10 x16, then 00.
//    out_valid high for 32 cycles; tw_addr 0..15 in SECOND; out_last on
//    cycle 48 only; in_ready low for cycles 33..48.
//  - Back-to-back frames, in_valid held high: in_ready gates for 16 cycles.
//    The next WAITING begins the cycle after out_last; no dead cycle;
//    sr_en stays 1 throughout.
//  - Gap: drop in_valid for 3 cycles at FIRST beat 5 -> cnt, phase and
//    state hold; sr_en=0, out_valid=0. Frame resumes and finishes 3 cycles
//    later. With FFT_CTRL_STALL_ERR_EN, err=1 from the gap onward.
//  - Stride: TW_STRIDE=2, TW_AW=4 -> tw_addr 0,2,..,14,0,2,..,14 over SECOND.
//  - Reset mid-SECOND (cnt=7): rst_n low for 1 cycle -> phase IDLE.
//    A following full frame reproduces the one-frame sequence exactly.

Source files
------------

// File: rtl/r2sdf_stage_ctrl.sv
// rtl/r2sdf_stage_ctrl.sv - radix-2 SDF FFT stage sequencer (optional FFT_CTRL_STALL_ERR_EN)
module r2sdf_stage_ctrl #(
    parameter int HALF      = 16,
    parameter int CW        = 4,
    parameter int TW_AW     = 4,
    parameter int TW_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       state,
    output logic             sr_en,
    output logic [TW_AW-1:0] tw_addr,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] FIRST   = 2'b01;
    localparam logic [1:0] SECOND  = 2'b10;
    localparam logic [1:0] WAITING = 2'b11;

    logic [1:0]       phase, phase_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             cnt_last;
    logic             accept;
    logic [TW_AW-1:0] tw_prod;

    assign cnt_last = (cnt == CW'(HALF - 1));
    // Held in reset, the stage must not advertise a beat even with in_valid high.
    assign accept   = in_valid & rst_n & (phase != SECOND);
    assign tw_prod  = TW_AW'(TW_AW'(cnt) * TW_AW'(TW_STRIDE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= IDLE;
            cnt   <= '0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        case (phase)
            IDLE: begin
                if (in_valid) begin
                    cnt_nxt   = CW'(1);
                    phase_nxt = WAITING;
                end
            end
            WAITING: begin
                if (in_valid) begin
                    if (cnt_last) begin
                        cnt_nxt   = '0;
                        phase_nxt = FIRST;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            FIRST: begin
                if (in_valid) begin
                    if (cnt_last) begin
                        cnt_nxt   = '0;
                        phase_nxt = SECOND;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                if (cnt_last) begin
                    cnt_nxt   = '0;
                    phase_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        state     = phase;
        in_ready  = (phase != SECOND);
        sr_en     = accept | (phase == SECOND);
        out_valid = ((phase == FIRST) & in_valid) | (phase == SECOND);
        out_last  = (phase == SECOND) & cnt_last;
        busy      = (phase != IDLE);
        tw_addr   = '0;
        if (phase == IDLE) begin
            state = accept ? WAITING : IDLE;
        end
        if (phase == SECOND) begin
            tw_addr = tw_prod;
        end
    end

`ifdef FFT_CTRL_STALL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (!in_valid && (((phase == WAITING) && (cnt != '0)) || (phase == FIRST))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// tb/tb_r2sdf_stage_ctrl.sv - scoreboard bench for r2sdf_stage_ctrl against a frame-position model
module tb_r2sdf_stage_ctrl;

    localparam int H  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready, sr_en, out_valid, out_last, busy, err;
    logic [1:0]    state;
    logic [AW-1:0] tw_addr;
    logic          in_ready2, sr_en2, out_valid2, out_last2, busy2, err2;
    logic [1:0]    state2;
    logic [AW-1:0] tw_addr2;

    r2sdf_stage_ctrl #(.HALF(H), .CW(4), .TW_AW(AW), .TW_STRIDE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state(state), .sr_en(sr_en), .tw_addr(tw_addr), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .err(err)
    );

    r2sdf_stage_ctrl #(.HALF(H), .CW(4), .TW_AW(AW), .TW_STRIDE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .state(state2), .sr_en(sr_en2), .tw_addr(tw_addr2), .out_valid(out_valid2),
        .out_last(out_last2), .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    st;
        logic          rdy;
        logic          sr;
        logic          ov;
        logic          last;
        logic          bsy;
        logic          er;
        logic [AW-1:0] tw;
        logic [AW-1:0] tw2;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   run    = 0;

    // A frame is 3*H positions; position 0 is the beat that leaves idle.
    bit m_active = 0;
    int m_pos    = 0;
    bit m_err    = 0;

    function automatic obs_t model(bit r, bit v);
        obs_t e;
        int   k;
        e = '0;
        e.rdy = 1'b1;
        e.er  = m_err;
        if (!r) begin
            e.er = 1'b0;
        end else if (!m_active) begin
            e.st = v ? 2'b11 : 2'b00;
            e.sr = v;
        end else if (m_pos < H) begin
            e.st  = 2'b11;
            e.sr  = v;
            e.bsy = 1'b1;
        end else if (m_pos < 2 * H) begin
            e.st  = 2'b01;
            e.sr  = v;
            e.ov  = v;
            e.bsy = 1'b1;
        end else begin
            k      = m_pos - 2 * H;
            e.st   = 2'b10;
            e.rdy  = 1'b0;
            e.sr   = 1'b1;
            e.ov   = 1'b1;
            e.bsy  = 1'b1;
            e.last = (k == H - 1);
            e.tw   = AW'(k % (1 << AW));
            e.tw2  = AW'((2 * k) % (1 << AW));
        end
        return e;
    endfunction

    task automatic advance(bit r, bit v);
        if (!r) begin
            m_active = 0;
            m_pos    = 0;
            m_err    = 0;
        end else begin
`ifdef FFT_CTRL_STALL_ERR_EN
            if (m_active && !v && m_pos < 2 * H) m_err = 1;
`endif
            if (!m_active) begin
                if (v) begin
                    m_active = 1;
                    m_pos    = 1;
                end
            end else if (v || m_pos >= 2 * H) begin
                m_pos++;
                if (m_pos == 3 * H) begin
                    m_active = 0;
                    m_pos    = 0;
                end
            end
        end
    endtask

    task automatic step(bit r, bit v);
        rst_n    = r;
        in_valid = v;
        q.push_back(model(r, v));
        @(posedge clk);
        advance(r, v);
        #1;
    endtask

    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        if (run) begin
            a = {state, in_ready, sr_en, out_valid, out_last, busy, err, tw_addr, tw_addr2};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t got %h", $time, a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t got st=%b rdy=%b sr=%b ov=%b last=%b busy=%b err=%b tw=%0d tw2=%0d exp st=%b rdy=%b sr=%b ov=%b last=%b busy=%b err=%b tw=%0d tw2=%0d",
                             $time, a.st, a.rdy, a.sr, a.ov, a.last, a.bsy, a.er, a.tw, a.tw2,
                             e.st, e.rdy, e.sr, e.ov, e.last, e.bsy, e.er, e.tw, e.tw2);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        run = 1;
        repeat (3) step(0, 1);
        for (int i = 0; i < 60; i++) step(1, i < 32);
        repeat (150) step(1, 1);
        step(0, 0);
        for (int i = 0; i < 60; i++) step(1, i < 21 || i >= 24);
        step(0, 0);
        for (int i = 0; i < 32; i++) step(1, 1);
        repeat (7) step(1, 0);
        step(0, 1);
        for (int i = 0; i < 60; i++) step(1, i < 32);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) step(0, $urandom_range(0, 1) == 1);
            else step(1, $urandom_range(0, 9) != 0);
        end
        repeat (4) step(1, 0);
        run = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
